wb_arbiter: RTL and testbench

Write-back arbiter sitting directly upstream of the 16×16-bit register file, driving its single write port (RegWrite/WriteReg/WriteData). It merges single-cycle ALU results with multi-cycle load returns, buffering loads in a small FIFO and giving ALU results strict priority. It also keeps a 16-bit pending-load scoreboard that decode uses to stall reads of registers whose load has not yet been written back.

---
 rtl/wb_arbiter_pkg.sv | 15 +
 rtl/wb_arbiter_if.sv | 38 +++
 rtl/wb_arbiter_fifo.sv | 61 ++++++
 rtl/wb_arbiter.sv | 102 ++++++++++
 tb/tb_wb_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the write-back arbiter slice.
//   REG_W    : register index width
//   DATA_W   : register data width
//   NUM_REGS : number of architectural registers (scoreboard width)
//   wb_req_t : one pending register-file write {rd, data}
package wb_arbiter_pkg;
    localparam int REG_W    = 4;
    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 16;

    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between decode/ALU/memory and the write-back arbiter.
//   master : producer side (ALU results, load issue/return) and consumer of
//            the register-file write port, scoreboard and error pulse
//   slave  : the arbiter itself
interface wb_arbiter_if;
    import wb_arbiter_pkg::*;

    logic                alu_valid;
    logic [REG_W-1:0]    alu_rd;
    logic [DATA_W-1:0]   alu_data;
    logic                ld_issue;
    logic [REG_W-1:0]    ld_issue_rd;
    logic                ld_valid;
    logic [REG_W-1:0]    ld_rd;
    logic [DATA_W-1:0]   ld_data;
    logic                ld_ready;
    logic [NUM_REGS-1:0] busy_mask;
    logic                RegWrite;
    logic [REG_W-1:0]    WriteReg;
    logic [DATA_W-1:0]   WriteData;
    logic                proto_err;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_issue, ld_issue_rd,
        output ld_valid, ld_rd, ld_data,
        input  ld_ready, busy_mask,
        input  RegWrite, WriteReg, WriteData, proto_err
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_issue, ld_issue_rd,
        input  ld_valid, ld_rd, ld_data,
        output ld_ready, busy_mask,
        output RegWrite, WriteReg, WriteData, proto_err
    );
endinterface

// File: rtl/wb_arbiter_fifo.sv
// wb_fifo: synchronous FIFO buffering returning loads.
//   clk, reset           : clock, synchronous active-high reset
//   push_i, push_data_i  : write an entry (ignored when full)
//   pop_i                : drop the head entry (ignored when empty)
//   head_o               : head entry, valid while !empty_o
//   full_o, empty_o      : occupancy flags (registered count)
//   count_o              : number of stored entries
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [W-1:0]               push_data_i,
    input  logic                       pop_i,
    output logic [W-1:0]               head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage is not reset; validity is tracked purely by the count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter driving the single register-file write port.
// ALU results have strict priority; load returns wait in wb_fifo. A 16-bit
// scoreboard tracks loads issued but not yet written back.
//   clk, reset : clock, synchronous active-high reset
//   bus        : wb_arbiter_if.slave (ALU/load inputs, ld_ready, busy_mask,
//                RegWrite/WriteReg/WriteData, proto_err)
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    wb_arbiter_if.slave   bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    wb_req_t             push_req;
    wb_req_t             head;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    logic                push;
    logic                pop;

    logic                reg_write_q,  reg_write_d;
    logic [REG_W-1:0]    write_reg_q,  write_reg_d;
    logic [DATA_W-1:0]   write_data_q, write_data_d;
    logic [NUM_REGS-1:0] busy_q,       busy_d;
    logic                proto_err_q,  proto_err_d;

    assign push_req.rd   = bus.ld_rd;
    assign push_req.data = bus.ld_data;
    assign push = bus.ld_valid && !fifo_full;
    assign pop  = !bus.alu_valid && !fifo_empty;

    wb_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(wb_req_t))
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (push_req),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    always_comb begin
        reg_write_d  = 1'b0;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        busy_d       = busy_q;

        if (bus.alu_valid) begin
            reg_write_d  = 1'b1;
            write_reg_d  = bus.alu_rd;
            write_data_d = bus.alu_data;
        end else if (!fifo_empty) begin
            reg_write_d  = 1'b1;
            write_reg_d  = head.rd;
            write_data_d = head.data;
            busy_d[head.rd] = 1'b0;
        end

        // Set is applied after clear; issuing to an already-busy register is
        // an error and leaves the scoreboard untouched.
        if (bus.ld_issue && !busy_q[bus.ld_issue_rd]) begin
            busy_d[bus.ld_issue_rd] = 1'b1;
        end

        proto_err_d = (bus.ld_issue  && busy_q[bus.ld_issue_rd])
                   || (bus.ld_valid  && fifo_full)
                   || (bus.alu_valid && busy_q[bus.alu_rd]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            busy_q       <= '0;
            proto_err_q  <= 1'b0;
        end else begin
            reg_write_q  <= reg_write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            busy_q       <= busy_d;
            proto_err_q  <= proto_err_d;
        end
    end

    assign bus.ld_ready  = (fifo_count < CNT_W'(DEPTH));
    assign bus.busy_mask = busy_q;
    assign bus.RegWrite  = reg_write_q;
    assign bus.WriteReg  = write_reg_q;
    assign bus.WriteData = write_data_q;
    assign bus.proto_err = proto_err_q;
endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wb_arbiter_if ifc ();

    wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    int vectors = 0;
    int errors  = 0;

    // Reference model: load FIFO as a queue, scoreboard as a bit vector,
    // expected register-file write port after each clock.
    wb_req_t     m_q[$];
    logic [15:0] m_busy = '0;
    logic        m_we   = 1'b0;
    logic [3:0]  m_wr   = '0;
    logic [15:0] m_wd   = '0;
    logic        m_err  = 1'b0;

    task automatic idle();
        ifc.alu_valid   = 1'b0;
        ifc.alu_rd      = '0;
        ifc.alu_data    = '0;
        ifc.ld_issue    = 1'b0;
        ifc.ld_issue_rd = '0;
        ifc.ld_valid    = 1'b0;
        ifc.ld_rd       = '0;
        ifc.ld_data     = '0;
    endtask

    task automatic model_step();
        logic [15:0] busy0;
        bit          ready;
        wb_req_t     e;
        if (reset) begin
            m_q.delete();
            m_busy = '0;
            m_we   = 1'b0;
            m_wr   = '0;
            m_wd   = '0;
            m_err  = 1'b0;
            return;
        end
        busy0 = m_busy;
        ready = (m_q.size() < DEPTH);
        m_err = (ifc.ld_issue && busy0[ifc.ld_issue_rd])
             || (ifc.ld_valid && !ready)
             || (ifc.alu_valid && busy0[ifc.alu_rd]);
        if (ifc.alu_valid) begin
            m_we = 1'b1;
            m_wr = ifc.alu_rd;
            m_wd = ifc.alu_data;
        end else if (m_q.size() > 0) begin
            e = m_q.pop_front();
            m_we = 1'b1;
            m_wr = e.rd;
            m_wd = e.data;
            m_busy[e.rd] = 1'b0;
        end else begin
            m_we = 1'b0;
        end
        if (ifc.ld_valid && ready) begin
            e.rd   = ifc.ld_rd;
            e.data = ifc.ld_data;
            m_q.push_back(e);
        end
        if (ifc.ld_issue && !busy0[ifc.ld_issue_rd]) m_busy[ifc.ld_issue_rd] = 1'b1;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        vectors++;
        if ({ifc.RegWrite, ifc.WriteReg, ifc.WriteData, ifc.busy_mask, ifc.proto_err, ifc.ld_ready}
            !== {1'b0, 4'd0, 16'd0, 16'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: got we=%b wr=%0d wd=%h busy=%h err=%b rdy=%b want 0/0/0000/0000/0/1",
                     ifc.RegWrite, ifc.WriteReg, ifc.WriteData, ifc.busy_mask, ifc.proto_err, ifc.ld_ready);
        end
    endtask

    task automatic test_alu_single();
        idle();
        ifc.alu_valid = 1'b1;
        ifc.alu_rd    = 4'd3;
        ifc.alu_data  = 16'h1234;
        tick();
        idle();
        vectors++;
        if ({ifc.RegWrite, ifc.WriteReg, ifc.WriteData, ifc.proto_err} !== {1'b1, 4'd3, 16'h1234, 1'b0}) begin
            errors++;
            $display("FAIL alu_write: got we=%b wr=%0d wd=%h err=%b want 1/3/1234/0",
                     ifc.RegWrite, ifc.WriteReg, ifc.WriteData, ifc.proto_err);
        end
        tick();
        vectors++;
        if (ifc.RegWrite !== 1'b0) begin
            errors++;
            $display("FAIL alu_one_cycle: got we=%b want 0", ifc.RegWrite);
        end
    endtask

    task automatic test_load_basic();
        idle();
        ifc.ld_issue    = 1'b1;
        ifc.ld_issue_rd = 4'd5;
        tick();
        idle();
        vectors++;
        if ({ifc.busy_mask, ifc.RegWrite} !== {16'h0020, 1'b0}) begin
            errors++;
            $display("FAIL ld_issue_busy: got busy=%h we=%b want 0020/0", ifc.busy_mask, ifc.RegWrite);
        end
        tick();
        ifc.ld_valid = 1'b1;
        ifc.ld_rd    = 4'd5;
        ifc.ld_data  = 16'hBEEF;
        tick();
        idle();
        vectors++;
        if ({ifc.RegWrite, ifc.busy_mask} !== {1'b0, 16'h0020}) begin
            errors++;
            $display("FAIL ld_push_plus1: got we=%b busy=%h want 0/0020", ifc.RegWrite, ifc.busy_mask);
        end
        tick();
        vectors++;
        if ({ifc.RegWrite, ifc.WriteReg, ifc.WriteData, ifc.busy_mask} !== {1'b1, 4'd5, 16'hBEEF, 16'h0000}) begin
            errors++;
            $display("FAIL ld_write: got we=%b wr=%0d wd=%h busy=%h want 1/5/beef/0000",
                     ifc.RegWrite, ifc.WriteReg, ifc.WriteData, ifc.busy_mask);
        end
        tick();
        vectors++;
        if (ifc.RegWrite !== 1'b0) begin
            errors++;
            $display("FAIL ld_write_once: got we=%b want 0", ifc.RegWrite);
        end
    endtask

    task automatic test_starvation();
        for (int i = 0; i < 5; i++) begin
            idle();
            ifc.ld_issue    = 1'b1;
            ifc.ld_issue_rd = 4'(8 + i);
            tick();
        end
        vectors++;
        if (ifc.busy_mask !== 16'h1F00) begin
            errors++;
            $display("FAIL starve_busy: got %h want 1f00", ifc.busy_mask);
        end
        for (int i = 0; i < 6; i++) begin
            idle();
            ifc.alu_valid = 1'b1;
            ifc.alu_rd    = 4'd1;
            ifc.alu_data  = 16'(i);
            ifc.ld_valid  = (i < 5);
            ifc.ld_rd     = 4'(8 + i);
            ifc.ld_data   = 16'hA000 + 16'(i);
            tick();
            vectors++;
            if ({ifc.RegWrite, ifc.WriteReg, ifc.WriteData, ifc.ld_ready, ifc.proto_err}
                !== {1'b1, 4'd1, 16'(i), (i < 3), (i == 4)}) begin
                errors++;
                $display("FAIL starve_alu[%0d]: got we=%b wr=%0d wd=%h rdy=%b err=%b want 1/1/%h/%b/%b",
                         i, ifc.RegWrite, ifc.WriteReg, ifc.WriteData, ifc.ld_ready, ifc.proto_err,
                         16'(i), (i < 3), (i == 4));
            end
        end
        idle();
        for (int j = 0; j < 4; j++) begin
            tick();
            vectors++;
            if ({ifc.RegWrite, ifc.WriteReg, ifc.WriteData} !== {1'b1, 4'(8 + j), 16'hA000 + 16'(j)}) begin
                errors++;
                $display("FAIL starve_drain[%0d]: got we=%b wr=%0d wd=%h want 1/%0d/%h",
                         j, ifc.RegWrite, ifc.WriteReg, ifc.WriteData, 8 + j, 16'hA000 + 16'(j));
            end
        end
        tick();
        vectors++;
        if ({ifc.RegWrite, ifc.busy_mask, ifc.ld_ready} !== {1'b0, 16'h1000, 1'b1}) begin
            errors++;
            $display("FAIL starve_done: got we=%b busy=%h rdy=%b want 0/1000/1",
                     ifc.RegWrite, ifc.busy_mask, ifc.ld_ready);
        end
        do_reset();
    endtask

    task automatic test_priority();
        idle();
        ifc.ld_issue    = 1'b1;
        ifc.ld_issue_rd = 4'd2;
        tick();
        idle();
        ifc.ld_valid = 1'b1;
        ifc.ld_rd    = 4'd2;
        ifc.ld_data  = 16'h2222;
        tick();
        idle();
        ifc.alu_valid = 1'b1;
        ifc.alu_rd    = 4'd1;
        ifc.alu_data  = 16'h1111;
        tick();
        idle();
        vectors++;
        if ({ifc.RegWrite, ifc.WriteReg, ifc.WriteData, ifc.busy_mask} !== {1'b1, 4'd1, 16'h1111, 16'h0004}) begin
            errors++;
            $display("FAIL prio_alu_first: got we=%b wr=%0d wd=%h busy=%h want 1/1/1111/0004",
                     ifc.RegWrite, ifc.WriteReg, ifc.WriteData, ifc.busy_mask);
        end
        tick();
        vectors++;
        if ({ifc.RegWrite, ifc.WriteReg, ifc.WriteData, ifc.busy_mask} !== {1'b1, 4'd2, 16'h2222, 16'h0000}) begin
            errors++;
            $display("FAIL prio_load_next: got we=%b wr=%0d wd=%h busy=%h want 1/2/2222/0000",
                     ifc.RegWrite, ifc.WriteReg, ifc.WriteData, ifc.busy_mask);
        end
    endtask

    task automatic test_double_issue();
        idle();
        ifc.ld_issue    = 1'b1;
        ifc.ld_issue_rd = 4'd7;
        tick();
        vectors++;
        if ({ifc.busy_mask, ifc.proto_err} !== {16'h0080, 1'b0}) begin
            errors++;
            $display("FAIL issue_first: got busy=%h err=%b want 0080/0", ifc.busy_mask, ifc.proto_err);
        end
        tick();
        idle();
        vectors++;
        if ({ifc.busy_mask, ifc.proto_err} !== {16'h0080, 1'b1}) begin
            errors++;
            $display("FAIL issue_twice: got busy=%h err=%b want 0080/1", ifc.busy_mask, ifc.proto_err);
        end
        tick();
        vectors++;
        if (ifc.proto_err !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse: got err=%b want 0", ifc.proto_err);
        end
        do_reset();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            idle();
            ifc.ld_issue    = 1'b1;
            ifc.ld_issue_rd = 4'(3 + i);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            idle();
            ifc.alu_valid = 1'b1;
            ifc.alu_rd    = 4'd1;
            ifc.alu_data  = 16'h5500 + 16'(i);
            ifc.ld_valid  = 1'b1;
            ifc.ld_rd     = 4'(3 + i);
            ifc.ld_data   = 16'hC000 + 16'(i);
            tick();
        end
        vectors++;
        if ({ifc.RegWrite, ifc.ld_ready, ifc.busy_mask} !== {1'b1, 1'b1, 16'h0038}) begin
            errors++;
            $display("FAIL pre_reset: got we=%b rdy=%b busy=%h want 1/1/0038",
                     ifc.RegWrite, ifc.ld_ready, ifc.busy_mask);
        end
        do_reset();
        vectors++;
        if ({ifc.RegWrite, ifc.busy_mask, ifc.ld_ready} !== {1'b0, 16'h0000, 1'b1}) begin
            errors++;
            $display("FAIL mid_reset: got we=%b busy=%h rdy=%b want 0/0000/1",
                     ifc.RegWrite, ifc.busy_mask, ifc.ld_ready);
        end
        for (int j = 0; j < 4; j++) begin
            tick();
            vectors++;
            if (ifc.RegWrite !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_flush[%0d]: got we=%b want 0", j, ifc.RegWrite);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            idle();
            ifc.alu_valid   = ($urandom_range(0, 9) < 3);
            ifc.alu_rd      = 4'($urandom_range(0, 15));
            ifc.alu_data    = 16'($urandom);
            ifc.ld_issue    = ($urandom_range(0, 9) < 3);
            ifc.ld_issue_rd = 4'($urandom_range(0, 15));
            ifc.ld_valid    = ($urandom_range(0, 9) < 4) && (ifc.ld_ready || $urandom_range(0, 9) == 0);
            ifc.ld_rd       = 4'($urandom_range(0, 15));
            ifc.ld_data     = 16'($urandom);
            tick();
            vectors++;
            if ({ifc.RegWrite, ifc.busy_mask, ifc.ld_ready, ifc.proto_err}
                !== {m_we, m_busy, (m_q.size() < DEPTH), m_err}) begin
                errors++;
                $display("FAIL rand_ctl[%0d]: got we=%b busy=%h rdy=%b err=%b want %b/%h/%b/%b",
                         n, ifc.RegWrite, ifc.busy_mask, ifc.ld_ready, ifc.proto_err,
                         m_we, m_busy, (m_q.size() < DEPTH), m_err);
            end
            if (m_we) begin
                vectors++;
                if ({ifc.WriteReg, ifc.WriteData} !== {m_wr, m_wd}) begin
                    errors++;
                    $display("FAIL rand_data[%0d]: got wr=%0d wd=%h want %0d/%h",
                             n, ifc.WriteReg, ifc.WriteData, m_wr, m_wd);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_alu_single();
        test_load_basic();
        test_starvation();
        test_priority();
        test_double_issue();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
